sram_frame_writer: RTL

- Fills the external SRAM with a pixel frame before template_match reads it back over its 20-bit address / 16-bit data port. This block is the write side of that SRAM path.
- Accepts a valid/ready stream of 16-bit pixel words and buffers them in a small FIFO.
- Writes each word to consecutive SRAM addresses from BASE_ADDR, using a two-cycle asynchronous-SRAM write strobe.
- Pulses done when FRAME_WORDS words have been written, so template_match can be started.

---
 rtl/sram_pkg.sv | 19 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/sram_frame_writer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types for the external SRAM write path: bus widths and the
// writer state encoding.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W = 20;
  localparam int unsigned SRAM_DATA_W = 16;

  typedef logic [SRAM_ADDR_W-1:0] sram_addr_t;
  typedef logic [SRAM_DATA_W-1:0] sram_data_t;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    SETUP,
    STROBE,
    DONE
  } wr_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with show-ahead read: rd_data always presents the
// head entry while not empty. Pointers carry one extra wrap bit so full and
// empty come straight from registered state.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush discards every stored entry in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage array; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/sram_frame_writer.sv
// Write side of the external SRAM path: buffers a valid/ready pixel stream
// and writes one frame to consecutive addresses from BASE_ADDR using a
// two-cycle (setup, strobe) asynchronous-SRAM write, then pulses done.
module sram_frame_writer
  import sram_pkg::*;
#(
  parameter int unsigned       ADDR_W      = SRAM_ADDR_W,
  parameter int unsigned       DATA_W      = SRAM_DATA_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       FRAME_WORDS = 1048576,
  parameter int unsigned       FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  // One extra counter bit so a frame covering the whole address space is legal.
  localparam int unsigned       CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(FRAME_WORDS - 1);

  wr_state_t         state;
  wr_state_t         state_next;
  logic [CNT_W-1:0]  word_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  logic [DATA_W-1:0] fifo_head;

  // Ready comes from the registered full flag only, so a pop on a full FIFO
  // frees the slot for the following cycle rather than the current one.
  assign in_ready  = busy && !fifo_full;
  assign fifo_push = in_valid && in_ready;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (fifo_flush),
    .push    (fifo_push),
    .wr_data (in_data),
    .pop     (fifo_pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .rd_data (fifo_head)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; the FIFO head is popped on every edge that enters SETUP.
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = ARMED;
          fifo_flush = 1'b1;
        end
      end
      ARMED: begin
        if (!fifo_empty) begin
          state_next = SETUP;
          fifo_pop   = 1'b1;
        end
      end
      SETUP: begin
        state_next = STROBE;
      end
      STROBE: begin
        if (word_cnt == LAST_WORD) begin
          state_next = DONE;
        end else if (!fifo_empty) begin
          state_next = SETUP;
          fifo_pop   = 1'b1;
        end else begin
          state_next = ARMED;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // SRAM strobes and status decoded from state alone, so rst releases the
  // bus asynchronously together with the state register.
  always_comb begin
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_ub_n  = 1'b1;
    sram_lb_n  = 1'b1;
    sram_dq_oe = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      ARMED: begin
        busy = 1'b1;
      end
      SETUP: begin
        busy       = 1'b1;
        sram_ce_n  = 1'b0;
        sram_ub_n  = 1'b0;
        sram_lb_n  = 1'b0;
        sram_dq_oe = 1'b1;
      end
      STROBE: begin
        busy       = 1'b1;
        sram_ce_n  = 1'b0;
        sram_ub_n  = 1'b0;
        sram_lb_n  = 1'b0;
        sram_dq_oe = 1'b1;
        sram_we_n  = 1'b0;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Word counter, address, write data and the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt  <= '0;
      sram_addr <= BASE_ADDR;
      sram_dq_o <= '0;
      overflow  <= 1'b0;
    end else if (state == IDLE && start) begin
      word_cnt  <= '0;
      sram_addr <= BASE_ADDR;
      overflow  <= 1'b0;
    end else begin
      if (state == STROBE) begin
        word_cnt  <= word_cnt + CNT_W'(1);
        sram_addr <= sram_addr + ADDR_W'(1);
      end
      if (fifo_pop) sram_dq_o <= fifo_head;
      if (busy && in_valid && !in_ready) overflow <= 1'b1;
    end
  end

endmodule
